// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg: shared opcodes, controller states, ALU ops and skip conditions
package acc_cpu_pkg;
  typedef enum logic [3:0] {
    OP_JNS = 4'h0, OP_LOAD = 4'h1, OP_STORE = 4'h2, OP_ADD = 4'h3,
    OP_SUBT = 4'h4, OP_INPUT = 4'h5, OP_OUTPUT = 4'h6, OP_HALT = 4'h7,
    OP_SKIPCOND = 4'h8, OP_JUMP = 4'h9, OP_CLEAR = 4'hA, OP_ADDI = 4'hB,
    OP_JUMPI = 4'hC, OP_LOADI = 4'hD, OP_STOREI = 4'hE, OP_ILL = 4'hF
  } opcode_t;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_IND, S_PTR, S_OPRD, S_EXEC, S_WR, S_IN, S_OUT, S_HALT
  } state_t;
  typedef enum logic [1:0] {ALU_PASS, ALU_ADD, ALU_SUB} alu_op_t;
  localparam logic [1:0] SKIP_NEG  = 2'b00;
  localparam logic [1:0] SKIP_ZERO = 2'b01;
  localparam logic [1:0] SKIP_POS  = 2'b10;
endpackage

// File: rtl/acc_alu.sv
// acc_alu: combinational pass/add/sub on the accumulator and a memory operand
module acc_alu import acc_cpu_pkg::*; #(
  parameter int W = 16
) (
  input  alu_op_t      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = op == ALU_ADD ? a + b : op == ALU_SUB ? a - b : b;
endmodule

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: multi-cycle accumulator CPU controller with indirect, skip, call and flow-controlled I/O
module acc_cpu_core import acc_cpu_pkg::*; #(
  parameter int DATA_W = 16,
  localparam int ADDR_W = DATA_W - 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] ir,
  output logic              halted,
  output logic              illegal
);
  state_t            state, dec_next;
  logic [ADDR_W-1:0] mar, pc_inc, dx;
  logic [DATA_W-1:0] mbr, alu_y;
  logic [1:0]        sc;
  logic              neg, zero, skip;
  opcode_t           op, dop;
  alu_op_t           alu_op;

  assign op     = opcode_t'(ir[DATA_W-1 -: 4]);
  assign dop    = opcode_t'(mem_rdata[DATA_W-1 -: 4]);
  assign dx     = mem_rdata[ADDR_W-1:0];
  assign pc_inc = pc + ADDR_W'(1);
  assign sc     = dx[ADDR_W-1 -: 2];
  assign neg    = ac[DATA_W-1];
  assign zero   = ac == '0;
  assign skip   = sc == SKIP_NEG ? neg : sc == SKIP_ZERO ? zero : sc == SKIP_POS ? !neg && !zero : 1'b0;
  assign alu_op = (op == OP_ADD || op == OP_ADDI) ? ALU_ADD : op == OP_SUBT ? ALU_SUB : ALU_PASS;

  assign mem_addr  = state == S_FETCH ? pc : mar;
  assign mem_we    = state == S_WR;
  assign mem_wdata = mbr;
  assign in_ready  = state == S_IN;
  assign out_valid = state == S_OUT;
  assign out_data  = ac;
  assign halted    = state == S_HALT;

  acc_alu #(.W(DATA_W)) u_alu (.op(alu_op), .a(ac), .b(mem_rdata), .y(alu_y));

  always_comb begin
    case (dop)
      OP_LOAD, OP_ADD, OP_SUBT:               dec_next = S_OPRD;
      OP_STORE, OP_JNS:                       dec_next = S_WR;
      OP_INPUT:                               dec_next = S_IN;
      OP_OUTPUT:                              dec_next = S_OUT;
      OP_HALT, OP_ILL:                        dec_next = S_HALT;
      OP_ADDI, OP_JUMPI, OP_LOADI, OP_STOREI: dec_next = S_IND;
      default:                                dec_next = S_FETCH;
    endcase
  end

  // mbr stages the word a later WR cycle writes: return address for JNS, ac otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ac      <= '0;
      ir      <= '0;
      mar     <= '0;
      mbr     <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir    <= mem_rdata;
          mar   <= dx;
          mbr   <= dop == OP_JNS ? DATA_W'(pc_inc) : ac;
          pc    <= dop == OP_JUMP ? dx : (dop == OP_SKIPCOND && skip) ? pc + ADDR_W'(2) : pc_inc;
          ac    <= dop == OP_CLEAR ? '0 : ac;
          illegal <= illegal || dop == OP_ILL;
          state <= dec_next;
        end
        S_IND: state <= S_PTR;
        S_PTR: begin
          if (op == OP_JUMPI) pc <= dx;
          else mar <= dx;
          state <= op == OP_JUMPI ? S_FETCH : op == OP_STOREI ? S_WR : S_OPRD;
        end
        S_OPRD: state <= S_EXEC;
        S_EXEC: begin
          mbr   <= mem_rdata;
          ac    <= alu_y;
          state <= S_FETCH;
        end
        S_WR: begin
          if (op == OP_JNS) pc <= mar + ADDR_W'(1);
          state <= S_FETCH;
        end
        S_IN: begin
          if (in_valid) ac <= in_data;
          state <= in_valid ? S_FETCH : S_IN;
        end
        S_OUT: state <= out_ready ? S_FETCH : S_OUT;
        default: state <= S_HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_cpu_core.sv
// tb_acc_cpu_core: directed programs with hand-computed results for the accumulator CPU
module tb_acc_cpu_core;
  import acc_cpu_pkg::*;
  logic clk = 0, reset = 0, load = 0;
  logic [11:0] mem_addr, pc;
  logic mem_we, in_valid = 0, in_ready, out_valid, out_ready = 0, halted, illegal;
  logic [15:0] mem_wdata, mem_rdata, in_data = 0, out_data, ac, ir;
  logic [15:0] mem [4096], img [4096];
  logic [15:0] p_addr, p_pc;
  logic p_we, p_in_ready, p_out_valid, p_halted, p_illegal;
  logic [19:0] p_wdata, p_rdata, p_out_data, p_ac, p_ir;
  logic [19:0] mem2 [256], img2 [256];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  acc_cpu_core dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .pc(pc), .ac(ac),
    .ir(ir), .halted(halted), .illegal(illegal)
  );

  acc_cpu_core #(.DATA_W(20), .RESET_PC(16'hFFFF)) dut20 (
    .clk(clk), .reset(reset), .mem_addr(p_addr), .mem_we(p_we), .mem_wdata(p_wdata),
    .mem_rdata(p_rdata), .in_valid(1'b0), .in_ready(p_in_ready), .in_data(20'h0),
    .out_valid(p_out_valid), .out_ready(1'b0), .out_data(p_out_data), .pc(p_pc), .ac(p_ac),
    .ir(p_ir), .halted(p_halted), .illegal(p_illegal)
  );

  always @(posedge clk) begin
    if (load) mem <= img;
    else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (load) mem2 <= img2;
    else begin
      if (p_we) mem2[p_addr[7:0]] <= p_wdata;
      p_rdata <= mem2[p_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_img();
    foreach (img[i]) img[i] = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    load = 1;
    step(1);
    reset = 0;
    load = 0;
  endtask

  initial begin
    foreach (img2[i]) img2[i] = '0;
    img2[8'hFF] = 20'hA0000;
    img2[8'h00] = 20'hF0000;
    step(1);

    // Add X
    clear_img();
    img[0] = 16'h1004; img[1] = 16'h3005; img[2] = 16'h7000;
    img[4] = 16'h0010; img[5] = 16'h0022;
    do_reset();
    check("rst_pc", pc, 0);
    check("rst_ac", ac, 0);
    check("rst_ir", ir, 0);
    check("rst_state", 32'(dut.state), 32'(S_FETCH));
    check("rst_flags", {halted, illegal, in_ready, out_valid, mem_we}, 0);
    step(9);
    check("addx_not_halted_c9", halted, 0);
    step(1);
    check("addx_halted_c10", halted, 1);
    check("addx_ac", ac, 16'h0032);
    check("addx_pc", pc, 3);

    // SUBT wrap and SKIPCOND
    clear_img();
    img[0] = 16'hA000; img[1] = 16'h4010; img[2] = 16'h8000; img[3] = 16'h7000;
    img[4] = 16'h8400; img[5] = 16'h8800; img[6] = 16'h7000; img[16'h10] = 16'h0001;
    do_reset();
    step(6);
    check("subt_wrap_ac", ac, 16'hFFFF);
    check("subt_pc", pc, 2);
    step(2);
    check("skip_neg_taken_pc", pc, 4);
    step(2);
    check("skip_zero_not_taken_pc", pc, 5);
    step(2);
    check("skip_pos_not_taken_pc", pc, 6);
    step(2);
    check("skip_halted", halted, 1);
    check("skip_final_pc", pc, 7);

    // JNS / ADDI / JUMPI / STOREI / LOADI
    clear_img();
    img[0] = 16'h0100; img[1] = 16'hE040; img[2] = 16'hA000; img[3] = 16'hD040; img[4] = 16'h7000;
    img[12'h101] = 16'hB020; img[12'h102] = 16'hC100;
    img[12'h20] = 16'h0030; img[12'h30] = 16'h0007; img[12'h40] = 16'h0050;
    do_reset();
    step(3);
    check("jns_pc", pc, 12'h101);
    check("jns_ret_word", mem[12'h100], 1);
    step(6);
    check("addi_ac", ac, 7);
    check("addi_pc", pc, 12'h102);
    step(4);
    check("jumpi_pc", pc, 1);
    step(5);
    check("storei_mem", mem[12'h50], 7);
    check("storei_pc", pc, 2);
    step(2);
    check("clear_ac", ac, 0);
    step(6);
    check("loadi_ac", ac, 7);
    check("loadi_pc", pc, 4);
    step(2);
    check("ind_halted", halted, 1);

    // I/O backpressure
    clear_img();
    img[0] = 16'h1010; img[1] = 16'h6000; img[2] = 16'h5000; img[3] = 16'h7000;
    img[12'h10] = 16'h1234;
    do_reset();
    step(6);
    for (int i = 0; i < 6; i++) begin
      check("out_valid_held", out_valid, 1);
      check("out_data_stable", out_data, 16'h1234);
      if (i == 5) out_ready = 1;
      step(1);
    end
    out_ready = 0;
    check("out_valid_dropped", out_valid, 0);
    step(2);
    check("in_ready_up", in_ready, 1);
    in_data = 16'hDEAD;
    step(3);
    check("in_ready_waiting", in_ready, 1);
    check("in_no_sample", ac, 16'h1234);
    in_data = 16'hBEEF;
    in_valid = 1;
    step(1);
    in_valid = 0;
    check("in_ac", ac, 16'hBEEF);
    check("in_ready_dropped", in_ready, 0);
    step(2);
    check("io_halted", halted, 1);

    // Reset mid-operation
    clear_img();
    img[0] = 16'h1010; img[1] = 16'h3010; img[2] = 16'h6000; img[12'h10] = 16'h0005;
    do_reset();
    step(6);
    check("pre_rst_oprd", 32'(dut.state), 32'(S_OPRD));
    reset = 1;
    step(1);
    reset = 0;
    check("oprd_rst_state", 32'(dut.state), 32'(S_FETCH));
    check("oprd_rst_pc", pc, 0);
    check("oprd_rst_ac", ac, 0);
    check("oprd_rst_we", mem_we, 0);
    step(1);
    check("oprd_rst_we_next", mem_we, 0);
    step(9);
    check("pre_rst_out_valid", out_valid, 1);
    check("pre_rst_out_ac", ac, 16'h000A);
    reset = 1;
    step(1);
    reset = 0;
    check("out_rst_valid", out_valid, 0);
    check("out_rst_state", 32'(dut.state), 32'(S_FETCH));
    check("out_rst_pc", pc, 0);
    check("out_rst_ac", ac, 0);
    step(1);
    check("out_rst_we_next", mem_we, 0);

    // DATA_W=20 instance: pc wrap and illegal opcode
    do_reset();
    check("w20_rst_pc", p_pc, 16'hFFFF);
    step(2);
    check("w20_wrap_pc", p_pc, 0);
    check("w20_no_illegal_yet", p_illegal, 0);
    step(2);
    check("w20_illegal", p_illegal, 1);
    check("w20_halted", p_halted, 1);
    check("w20_pc", p_pc, 1);
    step(3);
    check("w20_halt_absorbing", {p_halted, p_illegal, p_we}, 3'b110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
